// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and helpers for the architectural register file.
//   XLEN_DEF / TAGW_DEF : default data and producer-tag widths
//   X0_ADDR             : address of the hardwired-zero register
//   rf_clog2            : ceiling log2, used to size register addresses
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int TAGW_DEF = 4;
    localparam int X0_ADDR  = 0;

    function automatic int rf_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
// Ports:
//   en, addr        : read request
//   reg_data        : flattened register contents, register r at [r*XLEN +: XLEN]
//   reg_valid       : per-register valid bits (start-of-cycle state)
//   wr_acc          : per-write-port "accepted this cycle" flags
//   wr_addr/wr_data : flattened writeback address and data
//   data, valid     : read result
// Disabled port returns 0/0, x0 returns 0/valid, otherwise the highest-index
// accepted write to the same address is forwarded ahead of stored state.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = 32,
    parameter int NWR   = 2,
    parameter int REGAW = rf_clog2(NREG)
) (
    input  logic                  en,
    input  logic [REGAW-1:0]      addr,
    input  logic [NREG*XLEN-1:0]  reg_data,
    input  logic [NREG-1:0]       reg_valid,
    input  logic [NWR-1:0]        wr_acc,
    input  logic [NWR*REGAW-1:0]  wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    output logic [XLEN-1:0]       data,
    output logic                  valid
);

    always_comb begin
        data  = '0;
        valid = 1'b0;
        if (en) begin
            if (addr == REGAW'(X0_ADDR)) begin
                data  = '0;
                valid = 1'b1;
            end else begin
                data  = reg_data[int'(addr)*XLEN +: XLEN];
                valid = reg_valid[addr];
                // Ascending scan: a later (higher-index) match overrides.
                for (int w = 0; w < NWR; w++) begin
                    if (wr_acc[w] && (wr_addr[w*REGAW +: REGAW] == addr)) begin
                        data  = wr_data[w*XLEN +: XLEN];
                        valid = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/arch_regfile_sb.sv
// arch_regfile_sb: parametrised architectural register file with a tagged
// validity scoreboard, hardwired-zero x0, flush and pending-register count.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   rd_en/rd_addr         : NRD read requests
//   rd_data/rd_valid      : combinational read results (with write forwarding)
//   wr_en/wr_addr/wr_tag/wr_data : NWR writebacks, tag-filtered
//   iv_en/iv_addr/iv_tag  : destination invalidate (qualified by uop_valid)
//   uop_valid             : current micro-op valid
//   flush                 : revalidates every register, clears tags
//   source_not_ready      : a requested source of the current uop is invalid
//   pend_cnt              : registered count of invalid registers
module arch_regfile_sb
    import rf_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int TAGW = TAGW_DEF,
    localparam int REGAW = rf_clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*REGAW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_valid,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*REGAW-1:0] wr_addr,
    input  logic [NWR*TAGW-1:0]  wr_tag,
    input  logic [NWR*XLEN-1:0]  wr_data,
    input  logic                 iv_en,
    input  logic [REGAW-1:0]     iv_addr,
    input  logic [TAGW-1:0]      iv_tag,
    input  logic                 uop_valid,
    input  logic                 flush,
    output logic                 source_not_ready,
    output logic [REGAW:0]       pend_cnt
);

    logic [XLEN-1:0]      d_q    [NREG];
    logic [TAGW-1:0]      t_q    [NREG];
    logic [NREG-1:0]      v_q;

    logic [XLEN-1:0]      d_next [NREG];
    logic [TAGW-1:0]      t_next [NREG];
    logic [NREG-1:0]      v_next;
    logic [REGAW:0]       pend_next;

    logic [NREG*XLEN-1:0] d_flat;
    logic [NWR-1:0]       wr_acc;
    logic                 iv_do;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            d_flat[r*XLEN +: XLEN] = d_q[r];
        end
    end

    // A write is accepted if the target is valid (no producer outstanding)
    // or it carries the tag of the current producer. Anything else is a stale
    // writeback from a squashed or superseded producer. Writes in a flush
    // cycle are discarded, so they are neither stored nor forwarded.
    always_comb begin
        wr_acc = '0;
        for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && !flush &&
                (wr_addr[w*REGAW +: REGAW] != REGAW'(X0_ADDR)) &&
                (v_q[wr_addr[w*REGAW +: REGAW]] ||
                 (t_q[wr_addr[w*REGAW +: REGAW]] == wr_tag[w*TAGW +: TAGW]))) begin
                wr_acc[w] = 1'b1;
            end
        end
    end

    assign iv_do = iv_en && uop_valid && !flush && (iv_addr != REGAW'(X0_ADDR));

    // Invalidate is applied after the writes so it wins valid/tag on a
    // same-register collision while the written data is still kept.
    always_comb begin
        d_next = d_q;
        t_next = t_q;
        v_next = v_q;
        for (int w = 0; w < NWR; w++) begin
            if (wr_acc[w]) begin
                d_next[wr_addr[w*REGAW +: REGAW]] = wr_data[w*XLEN +: XLEN];
                v_next[wr_addr[w*REGAW +: REGAW]] = 1'b1;
            end
        end
        if (iv_do) begin
            v_next[iv_addr] = 1'b0;
            t_next[iv_addr] = iv_tag;
        end
        if (flush) begin
            v_next = '1;
            for (int r = 0; r < NREG; r++) begin
                t_next[r] = '0;
            end
        end
    end

    always_comb begin
        pend_next = '0;
        for (int r = 0; r < NREG; r++) begin
            pend_next = pend_next + {{REGAW{1'b0}}, ~v_next[r]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                d_q[r] <= '0;
                t_q[r] <= '0;
            end
            v_q      <= '1;
            pend_cnt <= '0;
        end else begin
            d_q      <= d_next;
            t_q      <= t_next;
            v_q      <= v_next;
            pend_cnt <= pend_next;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        rf_read_port #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .NWR   (NWR),
            .REGAW (REGAW)
        ) u_rd (
            .en        (rd_en[p]),
            .addr      (rd_addr[p*REGAW +: REGAW]),
            .reg_data  (d_flat),
            .reg_valid (v_q),
            .wr_acc    (wr_acc),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .data      (rd_data[p*XLEN +: XLEN]),
            .valid     (rd_valid[p])
        );
    end

    assign source_not_ready = uop_valid && |(rd_en & ~rd_valid);

endmodule

// File: tb/tb_arch_regfile_sb.sv
module tb_arch_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int TAGW  = 4;
    localparam int REGAW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NRD-1:0]       rd_en;
    logic [NRD*REGAW-1:0] rd_addr;
    logic [NRD*XLEN-1:0]  rd_data;
    logic [NRD-1:0]       rd_valid;
    logic [NWR-1:0]       wr_en;
    logic [NWR*REGAW-1:0] wr_addr;
    logic [NWR*TAGW-1:0]  wr_tag;
    logic [NWR*XLEN-1:0]  wr_data;
    logic                 iv_en;
    logic [REGAW-1:0]     iv_addr;
    logic [TAGW-1:0]      iv_tag;
    logic                 uop_valid;
    logic                 flush;
    logic                 source_not_ready;
    logic [REGAW:0]       pend_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state as plain arrays.
    logic [XLEN-1:0] m_d [NREG];
    logic            m_v [NREG];
    logic [TAGW-1:0] m_t [NREG];

    arch_regfile_sb #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .TAGW(TAGW)
    ) dut (
        .clk(clk), .reset(reset),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_tag(wr_tag), .wr_data(wr_data),
        .iv_en(iv_en), .iv_addr(iv_addr), .iv_tag(iv_tag),
        .uop_valid(uop_valid), .flush(flush),
        .source_not_ready(source_not_ready), .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rd_en = '0; rd_addr = '0;
        wr_en = '0; wr_addr = '0; wr_tag = '0; wr_data = '0;
        iv_en = 1'b0; iv_addr = '0; iv_tag = '0;
        uop_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_en[p] = 1'b1;
        rd_addr[p*REGAW +: REGAW] = a[REGAW-1:0];
    endtask

    task automatic set_wr(input int w, input int a, input int tag, input logic [XLEN-1:0] d);
        wr_en[w] = 1'b1;
        wr_addr[w*REGAW +: REGAW] = a[REGAW-1:0];
        wr_tag[w*TAGW +: TAGW] = tag[TAGW-1:0];
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_iv(input int a, input int tag);
        iv_en = 1'b1; uop_valid = 1'b1;
        iv_addr = a[REGAW-1:0];
        iv_tag = tag[TAGW-1:0];
    endtask

    function automatic bit m_acc(input int w);
        int a;
        a = int'(wr_addr[w*REGAW +: REGAW]);
        return wr_en[w] && !flush && a != 0 &&
               (m_v[a] || wr_tag[w*TAGW +: TAGW] == m_t[a]);
    endfunction

    function automatic int m_pend();
        int c = 0;
        for (int r = 0; r < NREG; r++) if (!m_v[r]) c++;
        return c;
    endfunction

    task automatic m_read(input int p, output logic [XLEN-1:0] d, output logic v);
        int a;
        a = int'(rd_addr[p*REGAW +: REGAW]);
        d = '0; v = 1'b0;
        if (rd_en[p]) begin
            if (a == 0) v = 1'b1;
            else begin
                d = m_d[a]; v = m_v[a];
                for (int w = 0; w < NWR; w++)
                    if (m_acc(w) && int'(wr_addr[w*REGAW +: REGAW]) == a) begin
                        d = wr_data[w*XLEN +: XLEN]; v = 1'b1;
                    end
            end
        end
    endtask

    // Advance one clock, updating the model from the inputs held this cycle.
    task automatic step();
        bit acc [NWR];
        for (int w = 0; w < NWR; w++) acc[w] = m_acc(w);
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin m_d[r] = '0; m_v[r] = 1'b1; m_t[r] = '0; end
        end else if (flush) begin
            for (int r = 0; r < NREG; r++) begin m_v[r] = 1'b1; m_t[r] = '0; end
        end else begin
            for (int w = 0; w < NWR; w++)
                if (acc[w]) begin
                    m_d[wr_addr[w*REGAW +: REGAW]] = wr_data[w*XLEN +: XLEN];
                    m_v[wr_addr[w*REGAW +: REGAW]] = 1'b1;
                end
            if (iv_en && uop_valid && iv_addr != 0) begin
                m_v[iv_addr] = 1'b0;
                m_t[iv_addr] = iv_tag;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle(); reset = 1'b1;
        step(); step();
        reset = 1'b0; #1;
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL reset_pend: got %0d expected 0", pend_cnt); end
        n_checks++; if (rd_data !== '0 || rd_valid !== 2'b00) begin n_fail++; $display("FAIL reset_idle_read: got data %0h valid %b expected 0 00", rd_data, rd_valid); end
        n_checks++; if (source_not_ready !== 1'b0) begin n_fail++; $display("FAIL reset_snr: got %b expected 0", source_not_ready); end
        set_rd(0, 5); set_rd(1, 7); uop_valid = 1'b1; #1;
        n_checks++; if (rd_data !== '0 || rd_valid !== 2'b11) begin n_fail++; $display("FAIL reset_read_x5_x7: got data %0h valid %b expected 0 11", rd_data, rd_valid); end
        n_checks++; if (source_not_ready !== 1'b0) begin n_fail++; $display("FAIL reset_read_snr: got %b expected 0", source_not_ready); end
    endtask

    task automatic test_invalidate_write();
        idle(); set_iv(3, 2); step();
        idle(); set_rd(0, 3); uop_valid = 1'b1; #1;
        n_checks++; if (rd_valid[0] !== 1'b0) begin n_fail++; $display("FAIL iv_x3_valid: got %b expected 0", rd_valid[0]); end
        n_checks++; if (source_not_ready !== 1'b1) begin n_fail++; $display("FAIL iv_x3_snr: got %b expected 1", source_not_ready); end
        n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL iv_x3_pend: got %0d expected 1", pend_cnt); end
        set_wr(0, 3, 2, 32'hDEAD); #1;
        n_checks++; if (rd_data[31:0] !== 32'hDEAD || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL fwd_x3: got %0h/%b expected dead/1", rd_data[31:0], rd_valid[0]); end
        n_checks++; if (source_not_ready !== 1'b0) begin n_fail++; $display("FAIL fwd_x3_snr: got %b expected 0", source_not_ready); end
        step();
        idle(); set_rd(0, 3); #1;
        n_checks++; if (rd_data[31:0] !== 32'hDEAD || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL x3_stored: got %0h/%b expected dead/1", rd_data[31:0], rd_valid[0]); end
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL x3_pend: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_stale_tag();
        idle(); set_iv(4, 1); step();
        idle(); set_iv(4, 3); step();
        idle(); set_wr(0, 4, 1, 32'h11); set_rd(1, 4); #1;
        n_checks++; if (rd_valid[1] !== 1'b0) begin n_fail++; $display("FAIL stale_no_fwd: got valid %b expected 0", rd_valid[1]); end
        step();
        idle(); set_rd(0, 4); #1;
        n_checks++; if (rd_valid[0] !== 1'b0 || rd_data[31:0] !== 32'h0) begin n_fail++; $display("FAIL stale_dropped: got %0h/%b expected 0/0", rd_data[31:0], rd_valid[0]); end
        n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL stale_pend: got %0d expected 1", pend_cnt); end
        idle(); set_wr(0, 4, 3, 32'h33); step();
        idle(); set_rd(0, 4); #1;
        n_checks++; if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== 32'h33) begin n_fail++; $display("FAIL tag3_write: got %0h/%b expected 33/1", rd_data[31:0], rd_valid[0]); end
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL tag3_pend: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_back_to_back_ports();
        idle(); set_wr(0, 6, 0, 32'hA); set_wr(1, 6, 0, 32'hB); set_rd(0, 6); #1;
        n_checks++; if (rd_data[31:0] !== 32'hB || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL dual_wr_fwd: got %0h/%b expected b/1", rd_data[31:0], rd_valid[0]); end
        step();
        idle(); set_rd(1, 6); #1;
        n_checks++; if (rd_data[63:32] !== 32'hB || rd_valid[1] !== 1'b1) begin n_fail++; $display("FAIL dual_wr_stored: got %0h/%b expected b/1", rd_data[63:32], rd_valid[1]); end
    endtask

    task automatic test_iv_write_same();
        idle(); set_iv(8, 5); set_wr(0, 8, 0, 32'h88); step();
        idle(); set_rd(0, 8); #1;
        n_checks++; if (rd_valid[0] !== 1'b0 || rd_data[31:0] !== 32'h88) begin n_fail++; $display("FAIL iv_wr_same: got %0h/%b expected 88/0", rd_data[31:0], rd_valid[0]); end
        n_checks++; if (pend_cnt !== 6'd1) begin n_fail++; $display("FAIL iv_wr_pend: got %0d expected 1", pend_cnt); end
        idle(); set_wr(0, 8, 0, 32'h77); step();
        idle(); set_rd(0, 8); #1;
        n_checks++; if (rd_valid[0] !== 1'b0 || rd_data[31:0] !== 32'h88) begin n_fail++; $display("FAIL iv_wr_oldtag: got %0h/%b expected 88/0", rd_data[31:0], rd_valid[0]); end
        idle(); set_wr(1, 8, 5, 32'h99); step();
        idle(); set_rd(0, 8); #1;
        n_checks++; if (rd_valid[0] !== 1'b1 || rd_data[31:0] !== 32'h99) begin n_fail++; $display("FAIL iv_wr_newtag: got %0h/%b expected 99/1", rd_data[31:0], rd_valid[0]); end
    endtask

    task automatic test_flush_x0();
        idle(); set_iv(9, 1); step();
        idle(); set_iv(10, 2); step();
        idle(); #1;
        n_checks++; if (pend_cnt !== 6'd2) begin n_fail++; $display("FAIL preflush_pend: got %0d expected 2", pend_cnt); end
        idle(); flush = 1'b1; set_wr(0, 11, 0, 32'h5555); set_iv(12, 7); step();
        idle(); #1;
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL flush_pend: got %0d expected 0", pend_cnt); end
        for (int r = 0; r < NREG; r += 2) begin
            idle(); set_rd(0, r); set_rd(1, r + 1); #1;
            n_checks++; if (rd_valid !== 2'b11) begin n_fail++; $display("FAIL flush_valid x%0d: got %b expected 11", r, rd_valid); end
        end
        idle(); set_rd(1, 11); #1;
        n_checks++; if (rd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL flush_wr_ignored: got %0h expected 0", rd_data[63:32]); end
        idle(); set_wr(0, 0, 0, 32'hFFFF); set_iv(0, 3); set_rd(0, 0); #1;
        n_checks++; if (rd_data[31:0] !== 32'h0 || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL x0_same_cycle: got %0h/%b expected 0/1", rd_data[31:0], rd_valid[0]); end
        step();
        idle(); set_rd(0, 0); #1;
        n_checks++; if (rd_data[31:0] !== 32'h0 || rd_valid[0] !== 1'b1) begin n_fail++; $display("FAIL x0_after: got %0h/%b expected 0/1", rd_data[31:0], rd_valid[0]); end
        n_checks++; if (pend_cnt !== 6'd0) begin n_fail++; $display("FAIL x0_pend: got %0d expected 0", pend_cnt); end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] ed;
        logic            ev;
        logic            esnr;
        for (int c = 0; c < 400; c++) begin
            idle();
            for (int p = 0; p < NRD; p++)
                if ($urandom_range(3) != 0) set_rd(p, $urandom_range(7));
            for (int w = 0; w < NWR; w++)
                if ($urandom_range(1) != 0) set_wr(w, $urandom_range(7), $urandom_range(3), $urandom);
            uop_valid = $urandom_range(3) != 0;
            iv_en = $urandom_range(2) == 0;
            iv_addr = REGAW'($urandom_range(7));
            iv_tag = TAGW'($urandom_range(3));
            flush = $urandom_range(24) == 0;
            #1;
            esnr = 1'b0;
            for (int p = 0; p < NRD; p++) begin
                m_read(p, ed, ev);
                if (rd_en[p] && !ev) esnr = uop_valid;
                n_checks++; if (rd_data[p*XLEN +: XLEN] !== ed || rd_valid[p] !== ev) begin n_fail++; $display("FAIL rand_read c%0d p%0d: got %0h/%b expected %0h/%b", c, p, rd_data[p*XLEN +: XLEN], rd_valid[p], ed, ev); end
            end
            n_checks++; if (source_not_ready !== esnr) begin n_fail++; $display("FAIL rand_snr c%0d: got %b expected %b", c, source_not_ready, esnr); end
            n_checks++; if (int'(pend_cnt) != m_pend()) begin n_fail++; $display("FAIL rand_pend c%0d: got %0d expected %0d", c, pend_cnt, m_pend()); end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_invalidate_write();
        test_stale_tag();
        test_back_to_back_ports();
        test_iv_write_same();
        test_flush_x0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arch_regfile_sb.md
# arch_regfile_sb

Parametrised integer architectural register file with a tagged validity scoreboard. It is the successor to the fixed 2-read/1-write register file. It adds configurable read and write port counts, data width and register count, plus per-register producer tags so that stale writebacks cannot revalidate a register. It also adds a hardwired-zero x0, a pipeline flush, and a pending-register counter. It sits between decode/issue, which reads sources and invalidates destinations, and writeback, which returns results.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, number of registers (power of 2, ≥2); REGAW = $clog2(NREG)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- TAGW, 4, producer tag width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rd_en  in  NRD  per-port read enable
- rd_addr  in  NRD*REGAW  read addresses, port p at [p*REGAW +: REGAW]
- rd_data  out  NRD*XLEN  read data (combinational)
- rd_valid  out  NRD  read data valid (combinational)
- wr_en  in  NWR  writeback enables
- wr_addr  in  NWR*REGAW  writeback addresses
- wr_tag  in  NWR*TAGW  producer tag of each writeback
- wr_data  in  NWR*XLEN  writeback data
- iv_en  in  1  destination invalidate request
- iv_addr  in  REGAW  register to invalidate
- iv_tag  in  TAGW  tag of the new producer
- uop_valid  in  1  current micro-op valid; qualifies iv_en and source_not_ready
- flush  in  1  synchronous flush: clears all pending state
- source_not_ready  out  1  a requested source of the current uop is invalid
- pend_cnt  out  REGAW+1  number of registers currently invalid (registered)

## Operation
- State per register r: data D[r], valid V[r], tag T[r].
- Accepted write: wr_en[w] & wr_addr≠0 & (V[a]==1 | wr_tag[w]==T[a]), evaluated against start-of-cycle state. It stores D[a]=wr_data and sets V[a]=1.
- Stale write (V[a]==0 and tag mismatch): dropped entirely. Neither data nor valid changes.
- Several accepted writes to the same address in one cycle: the highest port index wins for data.
- Invalidate: iv_en & uop_valid & iv_addr≠0 sets V=0 and T=iv_tag at the clock edge.
- Invalidate and accepted write to the same register in the same cycle: the write data is stored, but the invalidate wins for V and T. The final state is V=0, T=iv_tag.
- Reads: rd_en[p]=0 gives rd_data=0 and rd_valid=0.
- Read of address 0: rd_data=0, rd_valid=1.
- Read forwarding: if an accepted write targets rd_addr this cycle, the read returns the highest-index accepted write's data with rd_valid=1.
- Otherwise a read returns D and V.
- An invalidate issued in the same cycle does not affect reads; reads see pre-edge V.
- source_not_ready = uop_valid & |(rd_en & ~rd_valid).
- flush: all V=1 and all T=0; D is retained. Writes and invalidates in the flush cycle are ignored.
- reset: all D=0, V=1, T=0, pend_cnt=0. reset has priority over flush.
- pend_cnt: updated every cycle to the popcount of ~V after the edge, so it equals NREG − popcount(V) of the current state.

## Timing
- Reads, forwarding and source_not_ready are zero-latency combinational.
- Writes, invalidates, flush and reset take effect at the next rising edge of clk.
- pend_cnt reflects state one cycle after the causing edge's inputs (registered).
- Reset values: pend_cnt=0. With rd_en=0 after reset, rd_data=0, rd_valid=0 and source_not_ready=0.
- No multi-cycle handshake; issue stalls while source_not_ready=1 and holds its inputs.

## Structure
- Package rf_pkg holds the REGAW/clog2 helper, the X0 address constant, and the default XLEN/TAGW localparams.
- Sub-module rf_read_port, instantiated NRD times: address decode, x0 override, and priority forward mux over the NWR accepted-write vector.
- The write-acceptance logic, state arrays and popcount stay in the top level.

## Test plan
- Reset, then read x5 on port 0 and x7 on port 1 -> rd_data=0, rd_valid=1, pend_cnt=0.
- Invalidate x3 with tag 2, then read x3 -> rd_valid=0, source_not_ready=1, pend_cnt=1. Write x3 with tag 2, data 0xDEAD -> same-cycle forwarded rd_data=0xDEAD, rd_valid=1; next cycle V=1, pend_cnt=0.
- Invalidate x4 with tag 1, then invalidate x4 with tag 3, then write x4 with tag 1, data 0x11 -> write dropped; x4 stays invalid. A later write with tag 3, data 0x33 -> x4=0x33, valid.
- Same-cycle write to x6 on port 0 (0xA) and port 1 (0xB), with x6 valid -> read returns 0xB, stored value is 0xB.
- Invalidate x8 and write x8 (tag matching) in the same cycle -> next cycle x8 invalid with the new tag, data holds the written value.
- Invalidate x9 and x10, then pulse flush -> all rd_valid=1 and pend_cnt=0; write and invalidate to x0 -> x0 reads 0, valid.
